// File: rtl/rect_stream_sched.sv
// rtl/rect_stream_sched.sv - merges three rect corner-address streams into one tagged stream per feature
//
// Sequences one pass of FEATURE_NUM features per start pulse. Each feature
// contributes rect0 and rect1 (four corners each) and, when its info entry
// says so, rect2. Every merged address is tagged with its rect index and
// end-of-feature / end-of-pass markers.
//
// Optional build macro: RECT_SCHED_CHK_EN adds a sticky protocol error output (err).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               pulse, begins a pass when idle
//   busy, done          pass in progress / one-cycle end-of-pass pulse
//   info_valid/ready    feature-info handshake, info_nrects = rects in next feature
//   rect_valid/ready    per-rect source handshakes (bit i = rect i)
//   rect_data           per-rect addresses, slice i = rect i
//   rect_eot            per-rect eot pairs {last rect of stream, last corner}
//   addr_valid/ready    merged output handshake
//   addr_data           merged address
//   addr_rect           rect index of addr_data
//   addr_eot            {last address of pass, last address of feature}
//   feature_idx         feature currently being sequenced
//   err                 (RECT_SCHED_CHK_EN only) sticky protocol error

module rect_stream_sched #(
    parameter int W_ADDR      = 10,
    parameter int FEATURE_NUM = 2913,
    localparam int W_FEAT     = $clog2(FEATURE_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                info_valid,
    output logic                info_ready,
    input  logic [1:0]          info_nrects,
    input  logic [2:0]          rect_valid,
    output logic [2:0]          rect_ready,
    input  logic [3*W_ADDR-1:0] rect_data,
    input  logic [5:0]          rect_eot,
    output logic                addr_valid,
    input  logic                addr_ready,
    output logic [W_ADDR-1:0]   addr_data,
    output logic [1:0]          addr_rect,
    output logic [1:0]          addr_eot,
    output logic [W_FEAT-1:0]   feature_idx
`ifdef RECT_SCHED_CHK_EN
    ,
    output logic                err
`endif
);

    typedef enum logic [2:0] {IDLE, INFO, RECT0, RECT1, RECT2, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  corner;
    logic        three;      // current feature has rect2
    logic        in_rect;
    logic [1:0]  rect_sel;
    logic        sel_valid;
    logic [W_ADDR-1:0] sel_data;
    logic        last_rect;
    logic        last_feat;
    logic        hs;

    assign last_feat = (feature_idx == W_FEAT'(FEATURE_NUM - 1));

    // Source selection for the rect currently being forwarded.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        case (rect_sel)
            2'd0: begin
                sel_valid = rect_valid[0];
                sel_data  = rect_data[W_ADDR-1:0];
            end
            2'd1: begin
                sel_valid = rect_valid[1];
                sel_data  = rect_data[2*W_ADDR-1:W_ADDR];
            end
            2'd2: begin
                sel_valid = rect_valid[2];
                sel_data  = rect_data[3*W_ADDR-1:2*W_ADDR];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        info_ready = 1'b0;
        rect_ready = 3'b000;
        addr_valid = 1'b0;
        addr_data  = '0;
        addr_rect  = 2'd0;
        addr_eot   = 2'b00;
        in_rect    = 1'b0;
        rect_sel   = 2'd0;
        last_rect  = 1'b0;
        hs         = 1'b0;

        case (state)
            IDLE: if (start) state_nxt = INFO;
            INFO: begin
                busy       = 1'b1;
                info_ready = 1'b1;
                if (info_valid) state_nxt = RECT0;
            end
            RECT0: begin busy = 1'b1; in_rect = 1'b1; rect_sel = 2'd0; end
            RECT1: begin busy = 1'b1; in_rect = 1'b1; rect_sel = 2'd1; end
            RECT2: begin busy = 1'b1; in_rect = 1'b1; rect_sel = 2'd2; end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Zero-latency pass-through of the selected rect stream.
        if (in_rect) begin
            last_rect            = (rect_sel == 2'd2) || (rect_sel == 2'd1 && !three);
            addr_valid           = sel_valid;
            rect_ready[rect_sel] = addr_ready;
            addr_data            = sel_data;
            addr_rect            = rect_sel;
            addr_eot[0]          = sel_valid && (corner == 2'd3) && last_rect;
            addr_eot[1]          = sel_valid && (corner == 2'd3) && last_rect && last_feat;
            hs                   = sel_valid && addr_ready;
            if (hs && corner == 2'd3) begin
                if (!last_rect)      state_nxt = (rect_sel == 2'd0) ? RECT1 : RECT2;
                else if (last_feat)  state_nxt = DONE;
                else                 state_nxt = INFO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            corner      <= 2'd0;
            three       <= 1'b0;
            feature_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                feature_idx <= '0;
                corner      <= 2'd0;
            end
            // Only an explicit 3 selects rect2; 0/1 fall back to two rects.
            if (state == INFO && info_valid)
                three <= (info_nrects == 2'd3);
            if (hs) begin
                corner <= corner + 2'd1;
                if (corner == 2'd3 && last_rect && !last_feat)
                    feature_idx <= feature_idx + W_FEAT'(1);
            end
        end
    end

`ifdef RECT_SCHED_CHK_EN
    logic [1:0] sel_eot;

    always_comb begin
        sel_eot = 2'b00;
        case (rect_sel)
            2'd0:    sel_eot = rect_eot[1:0];
            2'd1:    sel_eot = rect_eot[3:2];
            2'd2:    sel_eot = rect_eot[5:4];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((hs && (sel_eot[0] != (corner == 2'd3))) ||
                     (state == INFO && info_valid && info_nrects[1] == 1'b0) ||
                     (hs && sel_eot[1] && !last_feat)) begin
            err <= 1'b1;
        end
    end
`else
    // Rect termination is by corner count; source eot is not needed here.
    logic unused_eot;
    assign unused_eot = ^rect_eot;
`endif

endmodule

// File: tb/tb_rect_stream_sched.sv
// tb/tb_rect_stream_sched.sv - directed self-checking bench for rect_stream_sched
module tb_rect_stream_sched;

    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic        info_valid, info_ready;
    logic [1:0]  info_nrects;
    logic [2:0]  rect_valid, rect_ready;
    logic [29:0] rect_data;
    logic [5:0]  rect_eot;
    logic        addr_valid, addr_ready;
    logic [9:0]  addr_data;
    logic [1:0]  addr_rect, addr_eot, feature_idx;
`ifdef RECT_SCHED_CHK_EN
    logic        err;
`endif

    rect_stream_sched #(.W_ADDR(10), .FEATURE_NUM(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .info_valid(info_valid), .info_ready(info_ready), .info_nrects(info_nrects),
        .rect_valid(rect_valid), .rect_ready(rect_ready), .rect_data(rect_data),
        .rect_eot(rect_eot), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .addr_data(addr_data), .addr_rect(addr_rect), .addr_eot(addr_eot),
        .feature_idx(feature_idx)
`ifdef RECT_SCHED_CHK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [9:0]  src_d [0:2][0:15];
    logic [1:0]  src_e [0:2][0:15];
    int          src_cnt [0:2];
    int          ptr [0:2];
    logic [15:0] exp_v [0:35];   // {data, rect, eot1, eot0, feature}
    int          exp_n;
    int          nr [0:2];

    // Generator contents and expected merged stream for a pass.
    task automatic build(input int a, input int b, input int c, input bit bad);
        int lf [0:2];
        logic [9:0] d;
        logic e0, e1;
        nr[0] = a; nr[1] = b; nr[2] = c;
        exp_n = 0;
        for (int k = 0; k < 3; k++) begin
            src_cnt[k] = 0; ptr[k] = 0; lf[k] = -1;
            for (int f = 0; f < 3; f++) if (nr[f] > k) lf[k] = f;
        end
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < nr[f]; k++)
                for (int q = 0; q < 4; q++) begin
                    d = 10'(f * 64 + k * 16 + q);
                    src_d[k][src_cnt[k]] = d;
                    src_e[k][src_cnt[k]] = {(q == 3 && f == lf[k]), (q == 3)};
                    src_cnt[k]++;
                    e0 = (q == 3 && k == nr[f] - 1);
                    e1 = e0 && (f == 2);
                    exp_v[exp_n] = {d, 2'(k), e1, e0, 2'(f)};
                    exp_n++;
                end
        if (bad) src_e[0][2] = src_e[0][2] | 2'b01;
    endtask

    task automatic drive_src();
        logic [29:0] dd;
        logic [5:0]  ee;
        dd = '0; ee = '0;
        for (int k = 0; k < 3; k++)
            if (ptr[k] < src_cnt[k]) begin
                dd[k*10 +: 10] = src_d[k][ptr[k]];
                ee[k*2 +: 2]   = src_e[k][ptr[k]];
            end
        rect_data = dd;
        rect_eot  = ee;
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if ({busy, done, info_ready, rect_ready, addr_valid, addr_data, addr_rect,
             addr_eot, feature_idx} !== 23'd0) begin
            n_fail++;
            $display("FAIL %s: outputs %b %b %b %b %b %h %h %b %h, required all zero", name,
                     busy, done, info_ready, rect_ready, addr_valid, addr_data, addr_rect,
                     addr_eot, feature_idx);
        end
    endtask

    task automatic run_pass(input bit rnd, input int gap, input bit restart, input int abort_at);
        int got = 0, info_ptr = 0, gap_left = 0, done_wait = 0;
        int gap_err = 0, r2_err = 0, stall_err = 0, extra = 0, cur_f;
        bit fin = 0, prev_stall = 0, gap_now;
        logic [9:0] prev_d = '0;
        logic [1:0] prev_r = '0;
        logic [2:0] vld = '0, rhs;
        logic       ihs;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || feature_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL start: busy=%b fidx=%0d, required busy=1 fidx=0", busy, feature_idx);
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            start       = restart && cyc == 4;
            info_valid  = (gap_left == 0) && (info_ptr < 3);
            info_nrects = (info_ptr < 3) ? 2'(nr[info_ptr]) : 2'd0;
            addr_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int k = 0; k < 3; k++)
                if (!vld[k]) vld[k] = (ptr[k] < src_cnt[k]) && (rnd ? $urandom_range(0, 1) == 1 : 1'b1);
            rect_valid = vld;
            drive_src();
            #1;
            if (abort_at >= 0 && got == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_reset_outputs("mid_pass_reset");
`ifdef RECT_SCHED_CHK_EN
                n_cmp++;
                if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: err=%b, required 0", err); end
`endif
                @(negedge clk);
                rst = 1'b0; rect_valid = '0; info_valid = 1'b0;
                for (int k = 0; k < 3; k++) ptr[k] = 0;
                return;
            end
            gap_now = gap_left > 0;
            if (gap_now && (addr_valid !== 1'b0 || rect_ready !== 3'b000 || info_ready !== 1'b1))
                gap_err++;
            if (got < exp_n) begin
                cur_f = int'(exp_v[got][1:0]);
                if (nr[cur_f] == 2 && rect_ready[2] === 1'b1) r2_err++;
            end
            if (prev_stall && (addr_valid !== 1'b1 || addr_data !== prev_d || addr_rect !== prev_r))
                stall_err++;
            if (done_wait == 1) begin
                n_cmp++;
                if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: done=%b, required 1", done); end
                done_wait = 2;
            end else if (done_wait == 2) begin
                n_cmp++;
                if ({done, busy} !== 2'b00) begin
                    n_fail++; $display("FAIL done_end: done=%b busy=%b, required 0 0", done, busy);
                end
                fin = 1;
            end else if (done === 1'b1) begin
                extra++;
            end
            if (addr_valid === 1'b1 && addr_ready === 1'b1) begin
                if (got < exp_n) begin
                    n_cmp++;
                    if ({addr_data, addr_rect, addr_eot, feature_idx} !== exp_v[got]) begin
                        n_fail++;
                        $display("FAIL item%0d: got %h/%0d/%b/%0d, required %h/%0d/%b/%0d", got,
                                 addr_data, addr_rect, addr_eot, feature_idx, exp_v[got][15:6],
                                 exp_v[got][5:4], exp_v[got][3:2], exp_v[got][1:0]);
                    end
                    if (got + 1 < exp_n && exp_v[got][1:0] == 2'd0 && exp_v[got+1][1:0] == 2'd1)
                        gap_left = gap;
                    got++;
                    if (got == exp_n) done_wait = 1;
                end else begin
                    extra++;
                end
            end
            prev_stall = addr_valid === 1'b1 && addr_ready === 1'b0;
            prev_d = addr_data;
            prev_r = addr_rect;
            rhs = rect_valid & rect_ready;
            ihs = info_valid && info_ready;
            if (fin) break;
            @(posedge clk);
            for (int k = 0; k < 3; k++) if (rhs[k]) begin ptr[k]++; vld[k] = 1'b0; end
            if (ihs) info_ptr++;
            if (gap_now) gap_left--;
        end
        n_cmp++;
        if (!fin || got != exp_n || extra != 0) begin
            n_fail++;
            $display("FAIL pass_len: fin=%0d got=%0d extra=%0d, required fin=1 got=%0d extra=0",
                     fin, got, extra, exp_n);
        end
        n_cmp++;
        if (r2_err != 0) begin n_fail++; $display("FAIL rect2_idle: %0d cycles, required 0", r2_err); end
        n_cmp++;
        if (stall_err != 0) begin n_fail++; $display("FAIL stall_hold: %0d cycles, required 0", stall_err); end
        if (gap > 0) begin
            n_cmp++;
            if (gap_err != 0) begin n_fail++; $display("FAIL info_gap: %0d cycles, required 0", gap_err); end
        end
        @(negedge clk);
        rect_valid = '0; info_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
`ifdef RECT_SCHED_CHK_EN
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: err=%b, required 0", err); end
`endif
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_full_three();
        build(3, 3, 3, 0);
        run_pass(0, 0, 0, -1);
`ifdef RECT_SCHED_CHK_EN
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL clean_err: err=%b, required 0", err); end
`endif
    endtask

    task automatic test_mixed();
        build(2, 3, 2, 0);
        run_pass(0, 0, 0, -1);
    endtask

    task automatic test_random_stall();
        build(3, 3, 3, 0);
        run_pass(1, 0, 0, -1);
        build(2, 3, 2, 0);
        run_pass(1, 0, 0, -1);
    endtask

    task automatic test_restart_ignored();
        build(3, 3, 3, 0);
        run_pass(0, 0, 1, -1);
    endtask

    task automatic test_reset_mid_pass();
        build(3, 3, 3, 0);
        run_pass(0, 0, 0, 14);
        build(3, 3, 3, 0);
        run_pass(1, 0, 0, -1);
    endtask

    task automatic test_info_gap();
        build(3, 3, 3, 0);
        run_pass(0, 5, 0, -1);
    endtask

    task automatic test_bad_eot();
        rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
        build(3, 3, 3, 1);
        run_pass(0, 0, 0, -1);
`ifdef RECT_SCHED_CHK_EN
        n_cmp++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: err=%b, required 1", err); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: err=%b, required 1", err); end
        rst = 1'b1; @(posedge clk); #1;
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: err=%b, required 0", err); end
        @(negedge clk); rst = 1'b0;
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; info_valid = 1'b0; info_nrects = 2'd0;
        rect_valid = '0; rect_data = '0; rect_eot = '0; addr_ready = 1'b0;
        test_reset();
        test_full_three();
        test_mixed();
        test_random_stall();
        test_restart_ignored();
        test_reset_mid_pass();
        test_info_gap();
        test_bad_eot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_stream_sched.md
Name: rect_stream_sched

Overview:
- Sequencer placed between the three per-rectangle address generators and the integral-image read port.
- Merges the three rect address streams into one ordered stream per feature: rect0 corners, then rect1, then rect2 only when the feature has three rects.
- Runs one pass over FEATURE_NUM features per start pulse.
- Fetches a per-feature rect count from a feature-info stream and tags every output address with its rect index and end-of-feature/end-of-pass markers.

Parameters:
- W_ADDR, 10, width of one corner address.
- FEATURE_NUM, 2913, features per pass.
- W_FEAT, $clog2(FEATURE_NUM) (localparam), feature index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  pulse; begins a pass when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of pass.
- info_valid  in  1  feature-info handshake valid.
- info_ready  out  1  feature-info handshake ready.
- info_nrects  in  2  rect count of the next feature (2 or 3).
- rect_valid  in  3  per-rect stream valid, bit i = rect i.
- rect_ready  out  3  per-rect stream ready.
- rect_data  in  3*W_ADDR  per-rect address; slice i = rect i.
- rect_eot  in  6  per-rect eot; bits [2i+1:2i]. Bit0 = last corner of rect, bit1 = last rect of stream.
- addr_valid  out  1  merged stream valid.
- addr_ready  in  1  merged stream ready.
- addr_data  out  W_ADDR  merged address.
- addr_rect  out  2  rect index of current address.
- addr_eot  out  2  bit0 = last address of feature; bit1 = last address of pass.
- feature_idx  out  W_FEAT  index of feature in progress.

Behaviour:
- Reset values: state IDLE; busy=0, done=0, info_ready=0, rect_ready=0, addr_valid=0, addr_data=0, addr_rect=0, addr_eot=0, feature_idx=0; corner and feature counters cleared.
- Reset mid-pass aborts immediately. Nothing is flushed from the generators (they reset on the same rst).
- States and transitions:
  - IDLE: start → INFO; clear feature_idx; busy=1. start while busy is ignored.
  - INFO: info_ready=1. On info_valid, latch nrects (values 0/1 treated as 2) → RECT0.
  - RECTk (k=0..2): zero-latency combinational pass-through of stream k. addr_valid=rect_valid[k], rect_ready[k]=addr_ready, addr_data=slice k, addr_rect=k. All other rect_ready bits 0.
  - Corner counter (2 bits) increments on each output handshake. On the 4th handshake (corner=3) the rect ends and the counter wraps to 0:
    - RECT0 → RECT1.
    - RECT1 → RECT2 if nrects=3; otherwise end-of-feature.
    - RECT2 → end-of-feature.
  - End-of-feature: if feature_idx==FEATURE_NUM-1 → DONE; otherwise feature_idx+1 → INFO.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- addr_eot[0]=1 only while presenting corner 3 of the feature's final rect. addr_eot[1]=addr_eot[0] AND feature_idx==FEATURE_NUM-1.
- Input rect_eot is passed through unused for sequencing; rect termination is by corner count only.
- Rect2 stream holds entries only for 3-rect features and is untouched for 2-rect features.
- Throughput: one address per cycle inside a feature. One INFO cycle minimum between features (info_valid held high gives 12 or 8 addresses plus 1 bubble per feature).
- Back-pressure: addr_ready low holds state and counters; output mirrors the input combinationally.

Optional Feature:
- Macro RECT_SCHED_CHK_EN.
- When defined: extra output port err (1 bit, reset 0, sticky until rst). Set when any of the following occur:
  - selected rect_eot bit0 disagrees with corner==3 on a handshake;
  - info_nrects is not 2 or 3 when latched;
  - rect stream bit1 eot is seen before the final feature.
- When undefined: no err port, no checking logic. Behaviour otherwise identical.

Test Plan:
- FEATURE_NUM=3, all info nrects=3, sources always valid, sink always ready, start pulse → 36 addresses. addr_rect sequence 0000 1111 2222 per feature. addr_eot[0] on addresses 12, 24, 36. addr_eot[1] only on address 36. done one cycle after address 36 is accepted.
- nrects pattern 2,3,2 → 28 addresses. rect_ready[2] never asserted during features 0 and 2. feature_idx steps 0→1→2.
- Random addr_ready (50%) and random rect_valid → output sequence identical to the ready-always run. No address dropped or duplicated. Counters frozen while stalled.
- start asserted again while busy → ignored, pass length unchanged. rst asserted mid-feature 1 → next cycle all outputs at reset values; new start runs a clean pass from feature 0.
- info_valid held low 5 cycles at feature boundary → addr_valid=0 and rect_ready=0 for those cycles, then resumes with rect 0 of the next feature.
- With RECT_SCHED_CHK_EN: rect0 asserts eot bit0 on its 3rd corner → err=1 and stays 1 until rst. Without the macro the same stimulus gives identical output stream and the design has no err port.
